// File: rtl/if_id_fetch_stage.sv
// Instruction-fetch stage and IF/ID pipeline register of the 5-stage MIPS datapath.
// Optional performance counters are compiled in with `define FETCH_PERF_CNT_EN.
module if_id_fetch_stage #(
   parameter logic [31:0] RESET_PC = 32'h0000_0000,
   parameter logic [31:0] PC_STEP  = 32'd4
) (
   input  logic        Clk,
   input  logic        Rst,
   input  logic        PCWrite,
   input  logic        IFIDWrite,
   input  logic        FlushSignal,
   input  logic        PCsrc,
   input  logic [1:0]  Jump,
   input  logic [31:0] BranchTarget,
   input  logic [31:0] JumpTarget,
   input  logic [31:0] RegTarget,
   input  logic [31:0] Instruction,
   output logic [31:0] PCOut,
   output logic [31:0] IFIDInstr,
   output logic [31:0] IFIDPCPlus4,
   output logic        IFIDValid,
   output logic [4:0]  IFIDrs,
   output logic [4:0]  IFIDrt
`ifdef FETCH_PERF_CNT_EN
   ,
   output logic [31:0] StallCount,
   output logic [31:0] FlushCount
`endif
);

   typedef enum logic {StBoot, StRun} state_t;

   state_t      r_state;
   logic [31:0] r_pc;
   logic [31:0] r_ifid_instr;
   logic [31:0] r_ifid_pc4;
   logic        r_ifid_valid;

   logic        w_redirect;
   logic [31:0] w_pc_plus;
   logic [31:0] w_next_pc;

   assign w_redirect = PCsrc | (Jump == 2'd1) | (Jump == 2'd2);
   assign w_pc_plus  = r_pc + PC_STEP;

   // A resolved redirect always beats the load-use hold.
   always_comb begin
      w_next_pc = w_pc_plus;
      if (Jump == 2'd2)      w_next_pc = RegTarget;
      else if (Jump == 2'd1) w_next_pc = JumpTarget;
      else if (PCsrc)        w_next_pc = BranchTarget;
      else if (PCWrite)      w_next_pc = r_pc;
   end

   always_ff @(posedge Clk or posedge Rst) begin
      if (Rst) begin
         r_state      <= StBoot;
         r_pc         <= RESET_PC;
         r_ifid_instr <= 32'h0;
         r_ifid_pc4   <= 32'h0;
         r_ifid_valid <= 1'b0;
      end else begin
         case (r_state)
            StBoot:  r_state <= StRun;
            default: r_state <= StRun;
         endcase
         r_pc <= w_next_pc;
         if (FlushSignal) begin
            r_ifid_instr <= 32'h0;
            r_ifid_valid <= 1'b0;
         end else if (!IFIDWrite) begin
            r_ifid_instr <= Instruction;
            r_ifid_pc4   <= w_pc_plus;
            r_ifid_valid <= 1'b1;
         end
      end
   end

   assign PCOut       = r_pc;
   assign IFIDInstr   = r_ifid_instr;
   assign IFIDPCPlus4 = r_ifid_pc4;
   assign IFIDValid   = r_ifid_valid;
   assign IFIDrs      = r_ifid_instr[25:21];
   assign IFIDrt      = r_ifid_instr[20:16];

`ifdef FETCH_PERF_CNT_EN
   logic [31:0] r_stall_cnt;
   logic [31:0] r_flush_cnt;
   logic        w_stall;

   assign w_stall = PCWrite & ~w_redirect;

   // Saturating counters: they stick at all-ones rather than wrap.
   always_ff @(posedge Clk or posedge Rst) begin
      if (Rst) begin
         r_stall_cnt <= 32'h0;
         r_flush_cnt <= 32'h0;
      end else begin
         if (w_stall && (r_stall_cnt != 32'hFFFF_FFFF)) r_stall_cnt <= r_stall_cnt + 32'd1;
         if (FlushSignal && (r_flush_cnt != 32'hFFFF_FFFF)) r_flush_cnt <= r_flush_cnt + 32'd1;
      end
   end

   assign StallCount = r_stall_cnt;
   assign FlushCount = r_flush_cnt;
`endif

endmodule

// File: tb/tb_if_id_fetch_stage.sv
// Self-checking bench for if_id_fetch_stage: a cycle-level fetch model plus
// hand-computed spot checks of PC sequencing, holds, redirects, wrap and reset.
module tb_if_id_fetch_stage;

   logic        Clk, Rst;
   logic        PCWrite, IFIDWrite, FlushSignal, PCsrc;
   logic [1:0]  Jump;
   logic [31:0] BranchTarget, JumpTarget, RegTarget, Instruction;
   logic [31:0] PCOut, IFIDInstr, IFIDPCPlus4;
   logic        IFIDValid;
   logic [4:0]  IFIDrs, IFIDrt;
`ifdef FETCH_PERF_CNT_EN
   logic [31:0] StallCount, FlushCount;
`endif

   int n_tests = 0;
   int n_fail  = 0;
   bit cmp_en  = 0;

   if_id_fetch_stage dut (
      .Clk(Clk), .Rst(Rst), .PCWrite(PCWrite), .IFIDWrite(IFIDWrite),
      .FlushSignal(FlushSignal), .PCsrc(PCsrc), .Jump(Jump),
      .BranchTarget(BranchTarget), .JumpTarget(JumpTarget), .RegTarget(RegTarget),
      .Instruction(Instruction), .PCOut(PCOut), .IFIDInstr(IFIDInstr),
      .IFIDPCPlus4(IFIDPCPlus4), .IFIDValid(IFIDValid), .IFIDrs(IFIDrs), .IFIDrt(IFIDrt)
`ifdef FETCH_PERF_CNT_EN
      , .StallCount(StallCount), .FlushCount(FlushCount)
`endif
   );

   initial begin
      Clk = 0;
      forever #5 Clk = ~Clk;
   end

   // Instruction memory contents: PC-dependent pattern.
   function automatic logic [31:0] mem_word(input logic [31:0] pc);
      return pc ^ 32'hA5A5_0000;
   endfunction

   assign Instruction = mem_word(PCOut);

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
      end
   endtask

   // Behavioural model of the architectural fetch state.
   logic [31:0] m_pc, m_instr, m_pc4, m_stall, m_flush;
   logic        m_valid;

   always @(posedge Clk or posedge Rst) begin
      if (Rst) begin
         m_pc = 32'h0; m_instr = 32'h0; m_pc4 = 32'h0; m_valid = 1'b0;
         m_stall = 32'h0; m_flush = 32'h0;
      end else begin
         logic [31:0] fetched, seq, target;
         logic        redir;
         fetched = mem_word(m_pc);
         seq     = m_pc + 32'd4;
         redir   = PCsrc || (Jump == 2'd1) || (Jump == 2'd2);
         if (PCWrite && !redir && m_stall != 32'hFFFF_FFFF) m_stall = m_stall + 1;
         if (FlushSignal && m_flush != 32'hFFFF_FFFF) m_flush = m_flush + 1;
         if (FlushSignal) begin
            m_instr = 32'h0; m_valid = 1'b0;
         end else if (!IFIDWrite) begin
            m_instr = fetched; m_pc4 = seq; m_valid = 1'b1;
         end
         target = (Jump == 2'd2) ? RegTarget :
                  (Jump == 2'd1) ? JumpTarget :
                  PCsrc ? BranchTarget : (PCWrite ? m_pc : seq);
         m_pc = target;
      end
   end

   // Per-cycle comparison against the model, well after the edge.
   always @(posedge Clk) begin
      #3;
      if (cmp_en) begin
         chk("cyc_pc",    PCOut, m_pc);
         chk("cyc_instr", IFIDInstr, m_instr);
         chk("cyc_pc4",   IFIDPCPlus4, m_pc4);
         chk("cyc_valid", 32'(IFIDValid), 32'(m_valid));
         chk("cyc_rs",    32'(IFIDrs), 32'(m_instr[25:21]));
         chk("cyc_rt",    32'(IFIDrt), 32'(m_instr[20:16]));
`ifdef FETCH_PERF_CNT_EN
         chk("cyc_stall_cnt", StallCount, m_stall);
         chk("cyc_flush_cnt", FlushCount, m_flush);
`endif
      end
   end

   task automatic edges(input int n);
      repeat (n) @(negedge Clk);
   endtask

   task automatic chk_reset_vals(input string tag);
      chk({tag, "_pc"},    PCOut, 32'h0);
      chk({tag, "_instr"}, IFIDInstr, 32'h0);
      chk({tag, "_pc4"},   IFIDPCPlus4, 32'h0);
      chk({tag, "_valid"}, 32'(IFIDValid), 32'h0);
`ifdef FETCH_PERF_CNT_EN
      chk({tag, "_stall_cnt"}, StallCount, 32'h0);
      chk({tag, "_flush_cnt"}, FlushCount, 32'h0);
`endif
   endtask

   initial begin
      Rst = 1; PCWrite = 0; IFIDWrite = 0; FlushSignal = 0; PCsrc = 0; Jump = 2'd0;
      BranchTarget = 32'h0; JumpTarget = 32'h0; RegTarget = 32'h0;
      #2;
      chk_reset_vals("reset");
      @(negedge Clk);
      Rst = 0; cmp_en = 1;

      // Free run from reset
      edges(1);
      chk("run_pc4",    PCOut, 32'h4);
      chk("run_instr0", IFIDInstr, 32'hA5A5_0000);
      chk("run_valid",  32'(IFIDValid), 32'h1);
      chk("run_pcp4",   IFIDPCPlus4, 32'h4);
      edges(3);
      chk("run_pc10",   PCOut, 32'h10);

      // Two-cycle hold at 0x10
      PCWrite = 1; IFIDWrite = 1;
      edges(2);
      chk("hold_pc",    PCOut, 32'h10);
      chk("hold_instr", IFIDInstr, 32'hA5A5_000C);
      PCWrite = 0; IFIDWrite = 0;
      edges(1);
      chk("rel_pc",     PCOut, 32'h14);
      chk("rel_instr",  IFIDInstr, 32'hA5A5_0010);

      // Branch plus flush at 0x20
      edges(3);
      chk("pre_br_pc",  PCOut, 32'h20);
      PCsrc = 1; BranchTarget = 32'h100; FlushSignal = 1;
      edges(1);
      PCsrc = 0; FlushSignal = 0;
      chk("br_pc",      PCOut, 32'h100);
      chk("br_instr",   IFIDInstr, 32'h0);
      chk("br_valid",   32'(IFIDValid), 32'h0);
      chk("br_pcp4",    IFIDPCPlus4, 32'h20);
      edges(1);
      chk("br_tgt_instr", IFIDInstr, 32'hA5A5_0100);
      chk("br_tgt_rs",  32'(IFIDrs), 32'd13);
      chk("br_tgt_rt",  32'(IFIDrt), 32'd5);

      // jr beats a simultaneous stall; Jump==3 is sequential
      Jump = 2'd2; RegTarget = 32'h40; PCWrite = 1;
      edges(1);
      chk("jr_pc",      PCOut, 32'h40);
      Jump = 2'd3; PCWrite = 0;
      edges(1);
      chk("j3_pc",      PCOut, 32'h44);

      // Wrap at the top of the address space
      Jump = 2'd1; JumpTarget = 32'hFFFF_FFFC;
      edges(1);
      Jump = 2'd0;
      chk("j_pc",       PCOut, 32'hFFFF_FFFC);
      edges(1);
      chk("wrap_pc",    PCOut, 32'h0);
      chk("wrap_pcp4",  IFIDPCPlus4, 32'h0);
      chk("wrap_instr", IFIDInstr, 32'h5A5A_FFFC);

      // Stall and flush on the same edge, then more stalls and one flush
      PCWrite = 1; IFIDWrite = 1; FlushSignal = 1;
      edges(1);
      FlushSignal = 0;
      chk("sf_pc",      PCOut, 32'h0);
      chk("sf_valid",   32'(IFIDValid), 32'h0);
      chk("sf_instr",   IFIDInstr, 32'h0);
      edges(2);
      PCWrite = 0; IFIDWrite = 0; FlushSignal = 1;
      edges(1);
      FlushSignal = 0;
`ifdef FETCH_PERF_CNT_EN
      chk("stall_cnt",  StallCount, 32'd5);
      chk("flush_cnt",  FlushCount, 32'd3);
`endif
      edges(2);

      // Asynchronous reset between edges
      @(posedge Clk);
      #2;
      Rst = 1;
      #1;
      chk_reset_vals("async_rst");
      @(negedge Clk);
      Rst = 0;
      edges(1);
      chk("boot_pc",    PCOut, 32'h4);
      chk("boot_valid", 32'(IFIDValid), 32'h1);
      chk("boot_instr", IFIDInstr, 32'hA5A5_0000);
      edges(3);
      cmp_en = 0;

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
